poll_sched: RTL
===============

# poll_sched

Autonomous poll scheduler and command-path arbiter sitting between `cmd_decoder` and the SPI slave interfaces (ADC addresses 4–6 by default). Every `PERIOD` clocks it injects a fixed per-channel command into the shared `master_data`/`valid_bus` stream, so ADC readings flow back through `cmd_encoder` without host traffic. Host bytes always keep priority and are never lost under the documented rate limit; poll rounds are deferred or abandoned instead.

## Interface
Parameters:
- `N_SRC`, `` `N_SRC ``, width of the one-hot address strobe bus.
- `N_CH`, 3, number of poll channels.
- `CH_ADDR`, `{8'd6,8'd5,8'd4}`, packed 8·N_CH; the target address of channel c is `CH_ADDR[8*c+:8]`.
- `CMD_BYTES`, 2, command length per channel (≥1).
- `PERIOD`, 4800000, clocks between round starts (100 ms at 48 MHz).
- `HOST_IDLE`, 8192, host-silence clocks required before a round may start.

Ports:
- `clk`, in, 1: `fpga_clk_48` domain.
- `n_rst`, in, 1: asynchronous, active-low reset.
- `host_data`, in, 8: byte from `cmd_decoder.q`.
- `host_valid_bus`, in, N_SRC: one-hot strobe from `cmd_decoder.valid_bus`.
- `enable`, in, 1: poller on/off.
- `ch_mask`, in, N_CH: channel c is polled when bit c is 1.
- `cmd_table`, in, 8·CMD_BYTES·N_CH: byte b of channel c is at `[8*(c*CMD_BYTES+b)+:8]`; b=0 is sent first.
- `clr_flags`, in, 1: synchronous clear of sticky flags.
- `q`, out, 8: registered byte to slave `in_data`.
- `valid_bus`, out, N_SRC: registered one-hot strobe to slave `in_ena`.
- `busy`, out, 1: state ≠ S_IDLE.
- `host_ovf`, out, 1: sticky; a host byte was dropped.
- `overrun`, out, 1: sticky; a period elapsed while a round was pending or running.
- `rounds_done`, out, 16: count of completed rounds, wraps.

## Operation
- Reset values: `q`=0, `valid_bus`=0, all flags and counters 0, state S_IDLE, `round_req`=0, pending register empty. `quiet_cnt` resets to HOST_IDLE, so the host counts as quiet.
- **Period counter:** counts while `enable`=1 and wraps at PERIOD−1.
  - On wrap it sets `round_req`.
  - If `round_req` is already set, or state ≠ S_IDLE, it sets `overrun` instead. Requests do not stack.
  - `enable`=0 holds the counter at 0 and clears `round_req`. A command already in flight finishes, then the block returns to S_IDLE.
- **quiet_cnt:** reloads to 0 on any `host_valid_bus` strobe and saturates at HOST_IDLE. `quiet` means `quiet_cnt`==HOST_IDLE.
- **S_IDLE:** when `round_req & quiet & |ch_mask`, clear `round_req`, select the lowest enabled channel, and go to S_EMIT with idx=0. If `round_req & ~|ch_mask`, clear `round_req` and count nothing.
- **S_EMIT:** each cycle, drive `q`=cmd byte[ch][idx] and `valid_bus`=one-hot(`CH_ADDR[ch]`). At idx=CMD_BYTES−1, go to S_GAP.
- **S_GAP:** one cycle with no poll byte.
  - If a host byte arrived during this round, abandon the rest of the round and go to S_IDLE without incrementing `rounds_done`.
  - Otherwise go to S_EMIT for the next higher enabled channel.
  - If there is no higher enabled channel, increment `rounds_done` and go to S_IDLE.
- **Host path:**
  - In S_IDLE or S_GAP with the pending register empty, a host byte is registered straight to `q`/`valid_bus`.
  - In S_EMIT, the host byte goes into a 1-deep pending register and is output in the next S_GAP or S_IDLE cycle.
  - A host byte arriving while pending is full is dropped and sets `host_ovf`.
  - If a fresh host strobe coincides with pending drain, the pending byte goes out first and the fresh byte is captured into pending.
- `ch_mask` and `cmd_table` are sampled per byte. Changes take effect at the next byte.
- `clr_flags` clears `host_ovf` and `overrun`. It is lower priority than a same-cycle set.

## Timing
- Host byte with poller idle: 1-cycle latency; `valid_bus` is high for exactly 1 cycle.
- Round start:
  - With `enable` rising before edge 1, the counter wraps at edge PERIOD and `round_req` is set.
  - The first poll byte is on `q` after edge PERIOD+1.
  - Each channel occupies CMD_BYTES+1 cycles (bytes, then the gap).
- Host delay during a poll command is ≤ CMD_BYTES cycles.
- Host rate limit: the host must keep ≥ CMD_BYTES+1 clocks between strobes for zero loss (the UART guarantees ~4000).
- Reset mid-round clears all outputs immediately (asynchronous). The pending host byte is lost.

## Structure
- Shared package/defines: `N_SRC`, default ADC channel addresses, and state encodings S_IDLE/S_EMIT/S_GAP.
- One natural sub-module, `rr_next`: a combinational "next enabled channel above index" finder. Everything else is flat.

## Test plan
All scenarios use PERIOD=100, HOST_IDLE=16, N_CH=3, CMD_BYTES=2, N_SRC=21, and `cmd_table` bytes 0x10,0x11,0x20,0x21,0x30,0x31.
- **Full round:** `enable`=1, `ch_mask`=3'b111 → at edges 101–108, 0x10/0x11 on bit4, gap, 0x20/0x21 on bit5, gap, 0x30/0x31 on bit6; `rounds_done`=1.
- **Masked round:** `ch_mask`=3'b010 → only 0x20,0x21 on bit5 each round; `ch_mask`=0 → no poll bytes and `rounds_done` stays 0.
- **Idle host byte:** host 0xA5 on bit8 while idle → `q`=0xA5 with bit8 high for exactly 1 cycle, the next cycle.
- **Host during round:**
  - Host 0x5A arrives during 0x10 → 0x11 is still sent, then 0x5A comes out in S_GAP.
  - The round is abandoned and `rounds_done` is unchanged.
  - No further round starts until 16 quiet cycles and the next wrap.
- **Overflow and overrun:**
  - Two host strobes on consecutive cycles during S_EMIT → the first is delayed and the second is dropped; `host_ovf`=1 until `clr_flags`.
  - With PERIOD=4 → `overrun`=1.
- **Reset mid-EMIT:** assert `n_rst` low mid-EMIT → `q`, `valid_bus`, `busy` go to 0 asynchronously; after release, the first byte appears again at edge 101.

Source files
------------

// File: rtl/poll_sched_pkg.sv
// Shared definitions for the poll scheduler: strobe-bus width, default ADC channel addresses, FSM states.
// Latency: n/a (definitions only).  Backpressure: n/a.
package poll_sched_pkg;
   localparam int N_SRC_DEF = 21;
   localparam int N_CH_DEF  = 3;
   localparam logic [8*N_CH_DEF-1:0] CH_ADDR_DEF = {8'd6, 8'd5, 8'd4};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_GAP  = 2'd2
   } state_t;
endpackage

// File: rtl/poll_sched_rr_next.sv
// Finds the lowest enabled channel above base (or at base when incl is set).
// Latency: combinational.  Backpressure: none.
module rr_next #(
   parameter int N_CH = 3,
   parameter int CW   = 2
) (
   input  logic [N_CH-1:0] mask,
   input  logic [CW-1:0]   base,
   input  logic            incl,
   output logic            found,
   output logic [CW-1:0]   nxt
);
   // Scan downwards so the lowest qualifying index is the last one written.
   always_comb begin
      found = 1'b0;
      nxt   = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask[i] && ((i > int'(base)) || (incl && (i == int'(base))))) begin
            found = 1'b1;
            nxt   = CW'(i);
         end
      end
   end
endmodule

// File: rtl/poll_sched.sv
// Poll scheduler: every PERIOD clocks injects per-channel commands into the slave strobe stream; host bytes have priority.
// Latency: host byte 1 clk when idle, up to CMD_BYTES extra during a poll command; first poll byte 1 clk after wrap.
// Backpressure: none upstream; a 1-deep pending register absorbs one host byte per command, further bytes drop (host_ovf).
module poll_sched
   import poll_sched_pkg::*;
#(
   parameter int                N_SRC     = N_SRC_DEF,
   parameter int                N_CH      = N_CH_DEF,
   parameter logic [8*N_CH-1:0] CH_ADDR   = CH_ADDR_DEF,
   parameter int                CMD_BYTES = 2,
   parameter int                PERIOD    = 4800000,
   parameter int                HOST_IDLE = 8192
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic [7:0]                  host_data,
   input  logic [N_SRC-1:0]            host_valid_bus,
   input  logic                        enable,
   input  logic [N_CH-1:0]             ch_mask,
   input  logic [8*CMD_BYTES*N_CH-1:0] cmd_table,
   input  logic                        clr_flags,
   output logic [7:0]                  q,
   output logic [N_SRC-1:0]            valid_bus,
   output logic                        busy,
   output logic                        host_ovf,
   output logic                        overrun,
   output logic [15:0]                 rounds_done
);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int IW = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int QW = $clog2(HOST_IDLE + 1);
   localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
   localparam logic [QW-1:0] Q_MAX  = QW'(HOST_IDLE);
   localparam logic [IW-1:0] I_LAST = IW'(CMD_BYTES - 1);

   state_t           state, state_n;
   logic [CW-1:0]    ch, ch_n;
   logic [IW-1:0]    idx, idx_n;
   logic             abort, abort_n;
   logic [PW-1:0]    pcnt;
   logic             round_req, req_clr, wrap;
   logic [QW-1:0]    quiet_cnt;
   logic             quiet, host_stb, done;
   logic             nx_found;
   logic [CW-1:0]    nx_ch;
   logic             pend_vld;
   logic [7:0]       pend_dat;
   logic [N_SRC-1:0] pend_bus;
   logic             host_free, host_direct, host_to_pend, pend_out, drop;
   logic [7:0]       poll_byte, poll_addr, q_n;
   logic [N_SRC-1:0] poll_bus, vb_n;

   assign host_stb = |host_valid_bus;
   assign quiet    = (quiet_cnt == Q_MAX);
   assign wrap     = enable && (pcnt == P_LAST);
   assign busy     = (state != S_IDLE);

   rr_next #(.N_CH(N_CH), .CW(CW)) u_rr_next (
      .mask  (ch_mask),
      .base  ((state == S_IDLE) ? '0 : ch),
      .incl  (state == S_IDLE),
      .found (nx_found),
      .nxt   (nx_ch)
   );

   always_comb begin
      state_n = state;
      ch_n    = ch;
      idx_n   = idx;
      abort_n = abort | host_stb;
      req_clr = 1'b0;
      done    = 1'b0;
      case (state)
         S_IDLE: begin
            abort_n = 1'b0;
            if (round_req && !nx_found) begin
               req_clr = 1'b1;
            end else if (round_req && quiet && enable && !host_stb && !pend_vld) begin
               req_clr = 1'b1;
               state_n = S_EMIT;
               ch_n    = nx_ch;
               idx_n   = '0;
            end
         end
         S_EMIT: begin
            if (idx == I_LAST) state_n = S_GAP;
            else               idx_n   = idx + 1'b1;
         end
         S_GAP: begin
            idx_n = '0;
            if (abort_n || !enable) begin
               state_n = S_IDLE;
            end else if (nx_found) begin
               state_n = S_EMIT;
               ch_n    = nx_ch;
            end else begin
               state_n = S_IDLE;
               done    = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Poll byte and strobe are looked up for the slot being loaded, so mask/table changes apply per byte.
   always_comb begin
      poll_byte = cmd_table[8*(int'(ch_n)*CMD_BYTES + int'(idx_n)) +: 8];
      poll_addr = CH_ADDR[8*int'(ch_n) +: 8];
      poll_bus  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (int'(poll_addr) == i) poll_bus[i] = 1'b1;
      end
   end

   // A free output slot goes to the pending byte first, then to a fresh host byte.
   always_comb begin
      host_free    = (state == S_IDLE) || (state == S_GAP);
      pend_out     = host_free && pend_vld;
      host_direct  = host_free && !pend_vld && host_stb;
      host_to_pend = host_stb && !host_direct;
      drop         = host_to_pend && pend_vld && !pend_out;
      q_n          = '0;
      vb_n         = '0;
      if (state_n == S_EMIT) begin
         q_n  = poll_byte;
         vb_n = poll_bus;
      end else if (pend_out) begin
         q_n  = pend_dat;
         vb_n = pend_bus;
      end else if (host_direct) begin
         q_n  = host_data;
         vb_n = host_valid_bus;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= S_IDLE;
         ch          <= '0;
         idx         <= '0;
         abort       <= 1'b0;
         q           <= '0;
         valid_bus   <= '0;
         pend_vld    <= 1'b0;
         pend_dat    <= '0;
         pend_bus    <= '0;
         rounds_done <= '0;
      end else begin
         state     <= state_n;
         ch        <= ch_n;
         idx       <= idx_n;
         abort     <= abort_n;
         q         <= q_n;
         valid_bus <= vb_n;
         if (host_to_pend && (!pend_vld || pend_out)) begin
            pend_vld <= 1'b1;
            pend_dat <= host_data;
            pend_bus <= host_valid_bus;
         end else if (pend_out) begin
            pend_vld <= 1'b0;
         end
         if (done) rounds_done <= rounds_done + 16'd1;
      end
   end

   // Requests never stack: a wrap with one outstanding or in progress only flags overrun.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pcnt      <= '0;
         round_req <= 1'b0;
         quiet_cnt <= Q_MAX;
         host_ovf  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (!enable) begin
            pcnt      <= '0;
            round_req <= 1'b0;
         end else begin
            pcnt <= wrap ? '0 : pcnt + 1'b1;
            if (wrap && !round_req && (state == S_IDLE)) round_req <= 1'b1;
            else if (req_clr)                            round_req <= 1'b0;
         end
         if (host_stb)           quiet_cnt <= '0;
         else if (!quiet)        quiet_cnt <= quiet_cnt + 1'b1;
         host_ovf <= drop | (host_ovf & ~clr_flags);
         overrun  <= (wrap && (round_req || (state != S_IDLE))) | (overrun & ~clr_flags);
      end
   end
endmodule
